// File: rtl/stage_decode.sv
// stage_decode: N-wide RV32IM decode stage; each slot decoded independently and registered once.
package stage_decode_pkg;
  typedef enum logic [1:0] {OPA_RS1, OPA_NPC, OPA_PC, OPA_ZERO} opa_select_e;
  typedef enum logic [2:0] {OPB_RS2, OPB_I_IMM, OPB_S_IMM, OPB_B_IMM, OPB_U_IMM, OPB_J_IMM} opb_select_e;
  typedef enum logic [2:0] {FU_ALU, FU_MULT, FU_LOAD, FU_STORE, FU_BRANCH} fu_type_e;
  typedef enum logic [1:0] {MEM_BYTE, MEM_HALF, MEM_WORD} mem_size_e;
  typedef enum logic [4:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND,
    ALU_MUL = 5'd16, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
  } alu_func_e;
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] PC;
    logic [31:0] NPC;
    logic        valid;
    logic        predict_taken;
    logic [31:0] predict_target;
  } IF_ID_PACKET;
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] PC;
    logic [31:0] NPC;
    logic        predict_taken;
    logic [31:0] predict_target;
    logic        valid;
    logic [4:0]  dest_reg_idx;
    logic [4:0]  src1_reg_idx;
    logic [4:0]  src2_reg_idx;
    logic        has_dest;
    opa_select_e opa_select;
    opb_select_e opb_select;
    alu_func_e   alu_func;
    fu_type_e    fu_type;
    mem_size_e   mem_size;
    logic        mem_unsigned;
    logic        cond_branch;
    logic        uncond_branch;
    logic        csr_op;
    logic        halt;
    logic        illegal;
  } ID_OOO_PACKET;
endpackage

module stage_decode
  import stage_decode_pkg::*;
#(
  parameter int N = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  IF_ID_PACKET  [N-1:0]   if_id_packet,
  output ID_OOO_PACKET [N-1:0]   id_ooo_packet
);
  // alt selects SUB/SRA; it only matters for funct3 0 and 5
  function automatic alu_func_e alu_of(input logic [2:0] f3, input logic alt);
    return f3 == 3'd0 ? (alt ? ALU_SUB : ALU_ADD) :
           f3 == 3'd1 ? ALU_SLL :
           f3 == 3'd2 ? ALU_SLT :
           f3 == 3'd3 ? ALU_SLTU :
           f3 == 3'd4 ? ALU_XOR :
           f3 == 3'd5 ? (alt ? ALU_SRA : ALU_SRL) :
           f3 == 3'd6 ? ALU_OR : ALU_AND;
  endfunction

  function automatic ID_OOO_PACKET decode(input IF_ID_PACKET p);
    ID_OOO_PACKET d;
    logic [6:0] f7;
    logic [2:0] f3;
    logic wr, r1, r2, ok;
    d = '0;
    f7 = p.inst[31:25];
    f3 = p.inst[14:12];
    wr = 1'b0;
    r1 = 1'b0;
    r2 = 1'b0;
    ok = 1'b1;
    case (p.inst[6:0])
      7'b0110011: begin
        {wr, r1, r2} = 3'b111;
        ok = f7 == 7'h00 || f7 == 7'h01 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        d.fu_type = f7 == 7'h01 ? FU_MULT : FU_ALU;
        d.alu_func = f7 == 7'h01 ? alu_func_e'({2'b10, f3}) : alu_of(f3, f7[5]);
      end
      7'b0010011: begin
        {wr, r1} = 2'b11;
        ok = f3 == 3'd1 ? f7 == 7'h00 : (f3 != 3'd5 || f7 == 7'h00 || f7 == 7'h20);
        d.opb_select = OPB_I_IMM;
        d.alu_func = alu_of(f3, f3 == 3'd5 && f7[5]);
      end
      7'b0000011: begin
        {wr, r1} = 2'b11;
        ok = f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7;
        d.fu_type = FU_LOAD;
        d.opb_select = OPB_I_IMM;
        d.mem_size = mem_size_e'(f3[1:0]);
        d.mem_unsigned = f3[2];
      end
      7'b0100011: begin
        {r1, r2} = 2'b11;
        ok = f3 < 3'd3;
        d.fu_type = FU_STORE;
        d.opb_select = OPB_S_IMM;
        d.mem_size = mem_size_e'(f3[1:0]);
      end
      7'b1100011: begin
        {r1, r2} = 2'b11;
        ok = f3 != 3'd2 && f3 != 3'd3;
        d.fu_type = FU_BRANCH;
        d.cond_branch = 1'b1;
        d.opa_select = OPA_PC;
        d.opb_select = OPB_B_IMM;
      end
      7'b1101111: begin
        wr = 1'b1;
        d.fu_type = FU_BRANCH;
        d.uncond_branch = 1'b1;
        d.opa_select = OPA_PC;
        d.opb_select = OPB_J_IMM;
      end
      7'b1100111: begin
        {wr, r1} = 2'b11;
        ok = f3 == 3'd0;
        d.fu_type = FU_BRANCH;
        d.uncond_branch = 1'b1;
        d.opb_select = OPB_I_IMM;
      end
      7'b0110111: begin
        wr = 1'b1;
        d.opa_select = OPA_ZERO;
        d.opb_select = OPB_U_IMM;
      end
      7'b0010111: begin
        wr = 1'b1;
        d.opa_select = OPA_PC;
        d.opb_select = OPB_U_IMM;
      end
      7'b1110011: begin
        d.halt = p.inst == 32'h10500073;
        d.csr_op = f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd3;
        {wr, r1} = {2{d.csr_op}};
        ok = d.halt || d.csr_op;
      end
      default: ok = 1'b0;
    endcase
    // an illegal slot keeps only its pass-through fields and the illegal flag
    if (ok) begin
      d.dest_reg_idx = wr ? p.inst[11:7] : 5'd0;
      d.src1_reg_idx = r1 ? p.inst[19:15] : 5'd0;
      d.src2_reg_idx = r2 ? p.inst[24:20] : 5'd0;
      d.has_dest = wr && p.inst[11:7] != 5'd0;
      d.valid = 1'b1;
    end else begin
      d = '0;
      d.illegal = 1'b1;
    end
    d.inst = p.inst;
    d.PC = p.PC;
    d.NPC = p.NPC;
    d.predict_taken = p.predict_taken;
    d.predict_target = p.predict_target;
    return p.valid ? d : '0;
  endfunction

  ID_OOO_PACKET [N-1:0] dec;

  always_comb
    for (int i = 0; i < N; i++) dec[i] = decode(if_id_packet[i]);

  always_ff @(posedge clock or negedge reset)
    if (!reset) id_ooo_packet <= '0;
    else id_ooo_packet <= dec;
endmodule

// File: tb/tb_stage_decode.sv
// tb_stage_decode: directed and randomized checks of stage_decode against an opcode-table reference model.
module tb_stage_decode;
  import stage_decode_pkg::*;
  localparam int N = 2;
  localparam logic [6:0] OPS [11] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h37, 7'h17, 7'h73, 7'h0f};

  logic clock = 1'b0;
  logic reset = 1'b0;
  IF_ID_PACKET  [N-1:0] if_id_packet;
  ID_OOO_PACKET [N-1:0] id_ooo_packet;
  int checks = 0;
  int errors = 0;

  stage_decode #(.N(N)) dut (
    .clock(clock),
    .reset(reset),
    .if_id_packet(if_id_packet),
    .id_ooo_packet(id_ooo_packet)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic IF_ID_PACKET mk(input logic [31:0] inst, input logic v, input logic [31:0] pc);
    IF_ID_PACKET p;
    p = '0;
    p.inst = inst;
    p.PC = pc;
    p.NPC = pc + 32'd4;
    p.valid = v;
    p.predict_target = pc + 32'd4;
    return p;
  endfunction

  function automatic IF_ID_PACKET rand_pkt();
    IF_ID_PACKET p;
    logic [31:0] x;
    int k;
    x = $urandom;
    k = $urandom_range(0, 12);
    if (k < 11) x[6:0] = OPS[k];
    case ($urandom_range(0, 3))
      0: x[31:25] = 7'h00;
      1: x[31:25] = 7'h01;
      2: x[31:25] = 7'h20;
      default: ;
    endcase
    if ($urandom_range(0, 19) == 0) x = 32'h10500073;
    p = mk(x, $urandom_range(0, 3) != 0, $urandom & ~32'h3);
    p.predict_taken = 1'($urandom_range(0, 1));
    p.predict_target = $urandom;
    return p;
  endfunction

  // pass-through fields of a legal valid slot
  function automatic ID_OOO_PACKET exp_base(input IF_ID_PACKET p);
    ID_OOO_PACKET e;
    e = '0;
    e.inst = p.inst;
    e.PC = p.PC;
    e.NPC = p.NPC;
    e.predict_taken = p.predict_taken;
    e.predict_target = p.predict_target;
    e.valid = 1'b1;
    return e;
  endfunction

  // reference: classify by opcode, look up legality and which register fields the format uses
  function automatic ID_OOO_PACKET ref_dec(input IF_ID_PACKET p);
    ID_OOO_PACKET e;
    logic [6:0] op, f7;
    logic [2:0] f3;
    bit legal, wr, u1, u2;
    alu_func_e base [8];
    alu_func_e mtab [8];
    base = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    mtab = '{ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    op = p.inst[6:0];
    f3 = p.inst[14:12];
    f7 = p.inst[31:25];
    e = exp_base(p);
    legal = 0; wr = 0; u1 = 0; u2 = 0;
    case (op)
      7'h33: begin
        legal = f7 == 7'h00 || f7 == 7'h01 || (f7 == 7'h20 && f3 inside {3'd0, 3'd5});
        wr = 1; u1 = 1; u2 = 1;
        e.fu_type = (f7 == 7'h01) ? FU_MULT : FU_ALU;
        e.alu_func = (f7 == 7'h01) ? mtab[f3] : (f7 == 7'h20) ? ((f3 == 3'd0) ? ALU_SUB : ALU_SRA) : base[f3];
      end
      7'h13: begin
        legal = (f3 == 3'd1) ? (f7 == 7'h00) : (f3 == 3'd5) ? (f7 inside {7'h00, 7'h20}) : 1'b1;
        wr = 1; u1 = 1;
        e.opb_select = OPB_I_IMM;
        e.alu_func = (f3 == 3'd5 && f7 == 7'h20) ? ALU_SRA : base[f3];
      end
      7'h03: begin
        legal = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        wr = 1; u1 = 1;
        e.fu_type = FU_LOAD;
        e.opb_select = OPB_I_IMM;
        e.mem_size = (f3[1:0] == 2'd0) ? MEM_BYTE : (f3[1:0] == 2'd1) ? MEM_HALF : MEM_WORD;
        e.mem_unsigned = f3[2];
      end
      7'h23: begin
        legal = f3 inside {3'd0, 3'd1, 3'd2};
        u1 = 1; u2 = 1;
        e.fu_type = FU_STORE;
        e.opb_select = OPB_S_IMM;
        e.mem_size = (f3 == 3'd0) ? MEM_BYTE : (f3 == 3'd1) ? MEM_HALF : MEM_WORD;
      end
      7'h63: begin
        legal = f3 inside {3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
        u1 = 1; u2 = 1;
        e.fu_type = FU_BRANCH; e.cond_branch = 1; e.opa_select = OPA_PC; e.opb_select = OPB_B_IMM;
      end
      7'h6f: begin
        legal = 1; wr = 1;
        e.fu_type = FU_BRANCH; e.uncond_branch = 1; e.opa_select = OPA_PC; e.opb_select = OPB_J_IMM;
      end
      7'h67: begin
        legal = f3 == 3'd0; wr = 1; u1 = 1;
        e.fu_type = FU_BRANCH; e.uncond_branch = 1; e.opb_select = OPB_I_IMM;
      end
      7'h37: begin
        legal = 1; wr = 1; e.opa_select = OPA_ZERO; e.opb_select = OPB_U_IMM;
      end
      7'h17: begin
        legal = 1; wr = 1; e.opa_select = OPA_PC; e.opb_select = OPB_U_IMM;
      end
      7'h73: begin
        if (p.inst == 32'h10500073) begin
          legal = 1; e.halt = 1;
        end else if (f3 inside {3'd1, 3'd2, 3'd3}) begin
          legal = 1; wr = 1; u1 = 1; e.csr_op = 1;
        end
      end
      default: legal = 0;
    endcase
    if (!p.valid) return '0;
    if (!legal) begin
      e.valid = 0;
      e.illegal = 1;
      return e;
    end
    e.dest_reg_idx = wr ? p.inst[11:7] : 5'd0;
    e.src1_reg_idx = u1 ? p.inst[19:15] : 5'd0;
    e.src2_reg_idx = u2 ? p.inst[24:20] : 5'd0;
    e.has_dest = wr && (p.inst[11:7] != 5'd0);
    return e;
  endfunction

  task automatic apply(input IF_ID_PACKET a, input IF_ID_PACKET b);
    if_id_packet[0] = a;
    if_id_packet[1] = b;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    if_id_packet = {rand_pkt(), rand_pkt()};
    if_id_packet[0].valid = 1'b1;
    #3;
    checks++;
    if (id_ooo_packet !== '0) begin
      errors++;
      $display("FAIL reset_hold got=%h exp=0", id_ooo_packet);
    end
    @(posedge clock);
    #1;
    checks++;
    if (id_ooo_packet !== '0) begin
      errors++;
      $display("FAIL reset_across_edge got=%h exp=0", id_ooo_packet);
    end
    @(negedge clock);
    if_id_packet[0].valid = 1'b0;
    if_id_packet[1].valid = 1'b0;
    reset = 1'b1;
    @(posedge clock);
    #1;
    checks++;
    if (id_ooo_packet !== '0) begin
      errors++;
      $display("FAIL reset_release_invalid got=%h exp=0", id_ooo_packet);
    end
  endtask

  task automatic test_nop();
    IF_ID_PACKET a;
    ID_OOO_PACKET e;
    a = mk(32'h00000013, 1'b1, 32'h0);
    apply(a, mk($urandom, 1'b0, 32'h40));
    e = exp_base(a);
    e.opb_select = OPB_I_IMM;
    checks++;
    if (id_ooo_packet[0] !== e) begin
      errors++;
      $display("FAIL nop_slot0 got=%h exp=%h", id_ooo_packet[0], e);
    end
    checks++;
    if (id_ooo_packet[1] !== '0) begin
      errors++;
      $display("FAIL nop_slot1_invalid got=%h exp=0", id_ooo_packet[1]);
    end
  endtask

  task automatic test_alu_mult();
    IF_ID_PACKET a, b;
    ID_OOO_PACKET ea, eb;
    a = mk(32'h002081B3, 1'b1, 32'h100);
    b = mk(32'h02208233, 1'b1, 32'h104);
    apply(a, b);
    ea = exp_base(a);
    ea.src1_reg_idx = 5'd1; ea.src2_reg_idx = 5'd2; ea.dest_reg_idx = 5'd3; ea.has_dest = 1'b1;
    eb = exp_base(b);
    eb.src1_reg_idx = 5'd1; eb.src2_reg_idx = 5'd2; eb.dest_reg_idx = 5'd4; eb.has_dest = 1'b1;
    eb.fu_type = FU_MULT; eb.alu_func = ALU_MUL;
    checks++;
    if (id_ooo_packet[0] !== ea) begin
      errors++;
      $display("FAIL add got=%h exp=%h", id_ooo_packet[0], ea);
    end
    checks++;
    if (id_ooo_packet[1] !== eb) begin
      errors++;
      $display("FAIL mul got=%h exp=%h", id_ooo_packet[1], eb);
    end
  endtask

  task automatic test_memory();
    IF_ID_PACKET a, b;
    ID_OOO_PACKET ea, eb;
    a = mk(32'h00812283, 1'b1, 32'h200);
    b = mk(32'h00512223, 1'b1, 32'h204);
    apply(a, b);
    ea = exp_base(a);
    ea.fu_type = FU_LOAD; ea.opb_select = OPB_I_IMM; ea.mem_size = MEM_WORD;
    ea.src1_reg_idx = 5'd2; ea.dest_reg_idx = 5'd5; ea.has_dest = 1'b1;
    eb = exp_base(b);
    eb.fu_type = FU_STORE; eb.opb_select = OPB_S_IMM; eb.mem_size = MEM_WORD;
    eb.src1_reg_idx = 5'd2; eb.src2_reg_idx = 5'd5;
    checks++;
    if (id_ooo_packet[0] !== ea) begin
      errors++;
      $display("FAIL lw got=%h exp=%h", id_ooo_packet[0], ea);
    end
    checks++;
    if (id_ooo_packet[1] !== eb) begin
      errors++;
      $display("FAIL sw got=%h exp=%h", id_ooo_packet[1], eb);
    end
  endtask

  task automatic test_control();
    IF_ID_PACKET a, b;
    ID_OOO_PACKET ea, eb;
    a = mk(32'h00208463, 1'b1, 32'h300);
    a.predict_taken = 1'b1;
    a.predict_target = 32'h308;
    b = mk(32'h10500073, 1'b1, 32'h304);
    apply(a, b);
    ea = exp_base(a);
    ea.fu_type = FU_BRANCH; ea.cond_branch = 1'b1; ea.opa_select = OPA_PC; ea.opb_select = OPB_B_IMM;
    ea.src1_reg_idx = 5'd1; ea.src2_reg_idx = 5'd2;
    eb = exp_base(b);
    eb.halt = 1'b1;
    checks++;
    if (id_ooo_packet[0] !== ea) begin
      errors++;
      $display("FAIL beq got=%h exp=%h", id_ooo_packet[0], ea);
    end
    checks++;
    if (id_ooo_packet[1] !== eb) begin
      errors++;
      $display("FAIL wfi got=%h exp=%h", id_ooo_packet[1], eb);
    end
  endtask

  task automatic test_illegal_mixed();
    apply(mk(32'hFFFFFFFF, 1'b1, 32'h400), mk(32'h002081B3, 1'b0, 32'h404));
    checks++;
    if ({id_ooo_packet[0].valid, id_ooo_packet[0].illegal} !== 2'b01) begin
      errors++;
      $display("FAIL illegal_slot0 got valid/illegal=%b exp=01", {id_ooo_packet[0].valid, id_ooo_packet[0].illegal});
    end
    checks++;
    if (id_ooo_packet[1] !== '0) begin
      errors++;
      $display("FAIL illegal_slot1_invalid got=%h exp=0", id_ooo_packet[1]);
    end
  endtask

  task automatic test_reset_midflight();
    IF_ID_PACKET a;
    a = mk(32'h002081B3, 1'b1, 32'h500);
    apply(a, a);
    reset = 1'b0;
    #1;
    checks++;
    if (id_ooo_packet !== '0) begin
      errors++;
      $display("FAIL reset_midflight got=%h exp=0", id_ooo_packet);
    end
    #1;
    reset = 1'b1;
    apply(a, mk(32'h00000013, 1'b1, 32'h504));
    checks++;
    if (id_ooo_packet[0] !== ref_dec(a)) begin
      errors++;
      $display("FAIL after_reset_capture got=%h exp=%h", id_ooo_packet[0], ref_dec(a));
    end
  endtask

  // back-to-back random bundles, one new bundle every cycle
  task automatic test_back_to_back();
    ID_OOO_PACKET e [N];
    IF_ID_PACKET a, b;
    for (int c = 0; c < 400; c++) begin
      a = rand_pkt();
      b = rand_pkt();
      e[0] = ref_dec(a);
      e[1] = ref_dec(b);
      apply(a, b);
      for (int i = 0; i < N; i++) begin
        checks++;
        if (e[i].illegal ? ({id_ooo_packet[i].valid, id_ooo_packet[i].illegal} !== 2'b01)
                         : (id_ooo_packet[i] !== e[i])) begin
          errors++;
          $display("FAIL random c%0d slot%0d inst=%h got=%h exp=%h", c, i, e[i].inst, id_ooo_packet[i], e[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_nop();
    test_alu_mult();
    test_memory();
    test_control();
    test_illegal_mixed();
    test_reset_midflight();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
